gesture_decoder: RTL and testbench

Downstream consumer of the per-frame aspect ratio produced by the red-blob bounding-box stage. Samples the 10-bit ratio once per VGA frame, classifies it into a hand-shape class, debounces the class over consecutive frames, and issues one-shot playback commands to the media controller over a valid/ready handshake. Runs in the 25 MHz pixel-clock domain alongside the VGA timing logic.

---
 rtl/gesture_decoder_if.sv | 11 +
 rtl/gesture_decoder.sv | 96 +++++++++
 tb/tb_gesture_decoder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/gesture_decoder_if.sv
// gesture_decoder_if: command handshake from the gesture decoder to the playback controller
//   cmd_valid  command pending
//   cmd_ready  controller accepts cmd this cycle
//   cmd        01 NEXT, 10 PLAY_PAUSE, 11 STOP
interface gesture_decoder_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  modport master(output cmd_valid, output cmd, input cmd_ready);
  modport slave(input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/gesture_decoder.sv
// gesture_decoder: samples blob aspect ratio once per frame, debounces its class, issues one-shot commands
//   clk25/resetn  pixel clock, async active-low reset
//   ratio         10-bit aspect ratio, 0 = no hand
//   cmd_if        valid/ready command channel (master side)
//   gesture       current accepted class: 00 NONE, 01 WIDE, 10 TALL, 11 SQUARE
//   drop_cnt      saturating count of accepts discarded while a command was pending
module gesture_decoder #(
  parameter int FRAME_CYCLES  = 420000,
  parameter int LOW_TH        = 70,
  parameter int HIGH_TH       = 140,
  parameter int STABLE_FRAMES = 4
) (
  input  logic                      clk25,
  input  logic                      resetn,
  input  logic [9:0]                ratio,
  gesture_decoder_if.master         cmd_if,
  output logic [1:0]                gesture,
  output logic [7:0]                drop_cnt
);
  localparam logic [1:0] ARMED = 2'd0, ISSUE = 2'd1, HOLD = 2'd2;
  logic [18:0] timer_q, timer_d;
  logic [1:0]  cls, cand_q, cand_d, gesture_q, gesture_d, state_q, state_d, cmd_q, cmd_d;
  logic [3:0]  cnt_q, cnt_d, cnt_n;
  logic [7:0]  drop_q, drop_d;
  logic        strobe, accept_q, accept_d, valid_q, valid_d, rearm_q, rearm_d;
  always_comb begin
    strobe    = timer_q == 19'(FRAME_CYCLES - 1);
    timer_d   = strobe ? '0 : timer_q + 19'd1;
    cls       = ratio == '0 ? 2'd0 : ratio < 10'(LOW_TH) ? 2'd1 : ratio > 10'(HIGH_TH) ? 2'd2 : 2'd3;
    cnt_n     = cls != cand_q ? 4'd1 : cnt_q == 4'(STABLE_FRAMES) ? cnt_q : cnt_q + 4'd1;
    cand_d    = strobe ? cls : cand_q;
    cnt_d     = strobe ? cnt_n : cnt_q;
    // a class already held as the gesture never re-accepts, so a held pose fires once
    accept_d  = strobe && cnt_n == 4'(STABLE_FRAMES) && cls != gesture_q;
    gesture_d = accept_d ? cls : gesture_q;
  end
  // accept_q lags the gesture update by one edge, so gesture_q already holds the accepted class here
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    rearm_d = rearm_q;
    case (state_q)
      ARMED: if (accept_q && gesture_q != 2'd0) begin
        cmd_d   = gesture_q;
        valid_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (cmd_if.cmd_ready) begin
          valid_d = 1'b0;
          state_d = HOLD;
        end
        if (accept_q) begin
          drop_d  = drop_q + {7'd0, drop_q != 8'hff};
          rearm_d = rearm_q | (gesture_q == 2'd0);
        end
      end
      HOLD: if (rearm_q || (accept_q && gesture_q == 2'd0)) begin
        state_d = ARMED;
        rearm_d = 1'b0;
      end
      default: state_d = ARMED;
    endcase
  end
  always_ff @(posedge clk25 or negedge resetn) begin
    if (!resetn) begin
      timer_q   <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      gesture_q <= '0;
      accept_q  <= 1'b0;
      state_q   <= ARMED;
      cmd_q     <= '0;
      valid_q   <= 1'b0;
      drop_q    <= '0;
      rearm_q   <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      gesture_q <= gesture_d;
      accept_q  <= accept_d;
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      valid_q   <= valid_d;
      drop_q    <= drop_d;
      rearm_q   <= rearm_d;
    end
  end
  assign cmd_if.cmd       = cmd_q;
  assign cmd_if.cmd_valid = valid_q;
  assign gesture          = gesture_q;
  assign drop_cnt         = drop_q;
endmodule

// File: tb/tb_gesture_decoder.sv
// tb_gesture_decoder: directed stimulus with a command scoreboard checked by an independent monitor
module tb_gesture_decoder;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] ratio = '0;
  logic [1:0] gesture;
  logic [7:0] drop_cnt;
  int         errors = 0;
  int         checks = 0;
  logic [1:0] exp_q[$];
  gesture_decoder_if cmd_if();
  gesture_decoder #(.FRAME_CYCLES(16), .LOW_TH(70), .HIGH_TH(140), .STABLE_FRAMES(4)) dut (
    .clk25(clk), .resetn(resetn), .ratio(ratio), .cmd_if(cmd_if.master), .gesture(gesture), .drop_cnt(drop_cnt));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask
  // the last edge of each hold is a sample strobe; returns 1 time unit after it
  task automatic hold(input int r, input int n);
    ratio = 10'(r);
    repeat (16 * n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (resetn && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cmd: unexpected command %0d at %0t", cmd_if.cmd, $time);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (cmd_if.cmd != e) begin
          errors++;
          $display("FAIL cmd: got %0d expected %0d at %0t", cmd_if.cmd, e, $time);
        end
      end
    end
  end
  initial begin
    int bnd[4];
    int bexp[4];
    bnd  = '{69, 70, 140, 141};
    bexp = '{1, 3, 3, 2};
    cmd_if.cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", cmd_if.cmd_valid, 0);
    chk("reset_cmd", cmd_if.cmd, 0);
    chk("reset_gesture", gesture, 0);
    chk("reset_drop", drop_cnt, 0);
    @(negedge clk);
    resetn = 1'b1;
    // single held TALL: exact latency and one pulse
    exp_q.push_back(2'd2);
    hold(200, 4);
    chk("t1_gesture", gesture, 2);
    chk("t1_valid_early", cmd_if.cmd_valid, 0);
    @(posedge clk); #1;
    chk("t1_valid", cmd_if.cmd_valid, 1);
    chk("t1_cmd", cmd_if.cmd, 2);
    @(posedge clk); #1;
    chk("t1_valid_drop", cmd_if.cmd_valid, 0);
    repeat (14) @(posedge clk);
    #1;
    hold(200, 2);
    hold(0, 4);
    chk("t1_release", gesture, 0);
    // class boundaries
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(2'(bexp[i]));
      hold(bnd[i], 4);
      chk("bound_gesture", gesture, bexp[i]);
      hold(0, 4);
      chk("bound_none", gesture, 0);
    end
    // debounce interrupted by a single TALL sample
    exp_q.push_back(2'd1);
    hold(50, 3);
    hold(200, 1);
    hold(50, 3);
    chk("deb_wait", gesture, 0);
    hold(50, 1);
    chk("deb_accept", gesture, 1);
    hold(0, 4);
    // stall: WIDE accepted while TALL pending is dropped
    cmd_if.cmd_ready = 1'b0;
    exp_q.push_back(2'd2);
    hold(200, 4);
    hold(0, 2);
    hold(50, 5);
    chk("stall_drop", drop_cnt, 1);
    chk("stall_valid", cmd_if.cmd_valid, 1);
    chk("stall_cmd", cmd_if.cmd, 2);
    chk("stall_gesture", gesture, 1);
    cmd_if.cmd_ready = 1'b1;
    hold(0, 4);
    chk("stall_done", cmd_if.cmd_valid, 0);
    // NONE accepted during ISSUE rearms straight through HOLD
    cmd_if.cmd_ready = 1'b0;
    exp_q.push_back(2'd1);
    hold(30, 4);
    hold(0, 5);
    chk("rearm_drop", drop_cnt, 2);
    chk("rearm_valid", cmd_if.cmd_valid, 1);
    chk("rearm_cmd", cmd_if.cmd, 1);
    cmd_if.cmd_ready = 1'b1;
    exp_q.push_back(2'd3);
    hold(100, 5);
    chk("rearm_gesture", gesture, 3);
    hold(0, 4);
    // no re-issue without release
    exp_q.push_back(2'd2);
    hold(200, 20);
    hold(30, 8);
    chk("switch_gesture", gesture, 1);
    chk("switch_queue", exp_q.size(), 0);
    exp_q.push_back(2'd1);
    hold(0, 4);
    hold(30, 5);
    chk("release_gesture", gesture, 1);
    hold(0, 4);
    // async reset mid-ISSUE drops the pending command
    cmd_if.cmd_ready = 1'b0;
    hold(200, 4);
    @(posedge clk); #1;
    chk("ar_valid_before", cmd_if.cmd_valid, 1);
    #3 resetn = 1'b0;
    #1;
    chk("ar_valid", cmd_if.cmd_valid, 0);
    chk("ar_cmd", cmd_if.cmd, 0);
    chk("ar_gesture", gesture, 0);
    chk("ar_drop", drop_cnt, 0);
    @(negedge clk);
    resetn = 1'b1;
    cmd_if.cmd_ready = 1'b1;
    exp_q.push_back(2'd2);
    hold(200, 4);
    chk("ar_regesture", gesture, 2);
    hold(200, 1);
    chk("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
